// File: rtl/audio_recorder.sv
// audio_recorder: threshold-triggered 8-bit sample capture into BRAM with random-access readback.
module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 1024,
    parameter RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);
    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) ram[addra] <= dina;
            ram_data <= ram[addra];
        end
    end
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low
        assign douta = ram_data;
    end else begin : g_high
        logic [RAM_WIDTH-1:0] douta_reg;
        always_ff @(posedge clka) begin
            if (rsta) douta_reg <= '0;
            else if (regcea) douta_reg <= ram_data;
        end
        assign douta = douta_reg;
    end
endmodule

module audio_recorder #(
    parameter int MAX_LEN    = 65536,
    parameter int TRIG_LEVEL = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_record,
    input  logic        stop_record,
    input  logic        signal_12khz,
    input  logic [7:0]  audio_in,
    input  logic [15:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        armed,
    output logic        recording,
    output logic [16:0] rec_len,
    output logic        rec_done
);
    localparam int AW = $clog2(MAX_LEN);
    typedef enum logic [1:0] {IDLE, ARMED, RECORD} state_t;
    state_t state, state_next;
    logic [15:0] wr_ptr, wr_ptr_next;
    logic [16:0] rec_len_next;
    logic        done_next, we;
    logic [8:0]  mag;
    logic [1:0]  idle_q;
    logic [7:0]  bram_out;
    assign mag = audio_in[7] ? 9'd0 - {1'b1, audio_in} : {1'b0, audio_in};
    always_comb begin
        state_next   = state;
        wr_ptr_next  = wr_ptr;
        rec_len_next = rec_len;
        done_next    = 1'b0;
        we           = 1'b0;
        case (state)
            IDLE: if (start_record) begin
                state_next  = ARMED;
                wr_ptr_next = '0;
            end
            ARMED: if (stop_record) begin
                state_next   = IDLE;
                rec_len_next = '0;
                done_next    = 1'b1;
            end else if (signal_12khz && mag >= 9'(TRIG_LEVEL)) begin
                we          = 1'b1;
                wr_ptr_next = 16'd1;
                state_next  = RECORD;
            end
            RECORD: if (stop_record) begin
                state_next   = IDLE;
                rec_len_next = 17'(wr_ptr);
                done_next    = 1'b1;
            end else if (signal_12khz) begin
                we = 1'b1;
                if (wr_ptr == 16'(MAX_LEN - 1)) begin
                    state_next   = IDLE;
                    rec_len_next = 17'(MAX_LEN);
                    done_next    = 1'b1;
                end else begin
                    wr_ptr_next = wr_ptr + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rec_len  <= '0;
            rec_done <= 1'b0;
            idle_q   <= '0;
        end else begin
            state    <= state_next;
            wr_ptr   <= wr_ptr_next;
            rec_len  <= rec_len_next;
            rec_done <= done_next;
            idle_q   <= {idle_q[0], state == IDLE};
        end
    end
    assign armed     = state == ARMED;
    assign recording = state == RECORD;
    // The two-stage read pipeline still holds write-side data for two cycles after returning to IDLE.
    assign rd_data   = (state == IDLE && &idle_q) ? bram_out : 8'd0;
    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH(8),
        .RAM_DEPTH(MAX_LEN),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE")
    ) bram (
        .addra(state == IDLE ? rd_addr[AW-1:0] : wr_ptr[AW-1:0]),
        .dina(audio_in),
        .clka(clk_in),
        .wea(we),
        .ena(1'b1),
        .rsta(rst_in),
        .regcea(1'b1),
        .douta(bram_out)
    );
endmodule

// File: tb/tb_audio_recorder.sv
// tb_audio_recorder: scoreboard bench over three parameterisations (default, TRIG_LEVEL=50, MAX_LEN=16).
module tb_audio_recorder;
    localparam int ML [3] = '{65536, 65536, 16};
    localparam int TL [3] = '{0, 50, 0};
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start, stop, stb, armed, recording, done;
    logic [7:0]  ain [3];
    logic [15:0] raddr [3];
    logic [7:0]  rdata [3];
    logic [16:0] rlen [3];
    int cyc = 0, n_cmp = 0, n_bad = 0;
    typedef struct {int d; int due; logic [7:0] val; int addr;} rd_exp_t;
    typedef struct {int d; logic [16:0] len;} done_exp_t;
    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        audio_recorder #(.MAX_LEN(ML[g]), .TRIG_LEVEL(TL[g])) dut (
            .clk_in(clk), .rst_in(rst), .start_record(start[g]), .stop_record(stop[g]),
            .signal_12khz(stb[g]), .audio_in(ain[g]), .rd_addr(raddr[g]), .rd_data(rdata[g]),
            .armed(armed[g]), .recording(recording[g]), .rec_len(rlen[g]), .rec_done(done[g])
        );
    end

    always @(negedge clk) begin
        rd_exp_t r;
        done_exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (done[d]) begin
                n_cmp++;
                if (done_q.size() == 0 || done_q[0].d != d) begin
                    n_bad++;
                    $display("FAIL rec_done dut%0d: unexpected pulse at cycle %0d, rec_len=%0d", d, cyc, rlen[d]);
                end else begin
                    e = done_q.pop_front();
                    if (rlen[d] !== e.len) begin
                        n_bad++;
                        $display("FAIL rec_len dut%0d: got %0d expected %0d", d, rlen[d], e.len);
                    end
                end
            end
        end
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            n_cmp++;
            if (rdata[r.d] !== r.val) begin
                n_bad++;
                $display("FAIL rd_data dut%0d addr %0d: got %0d expected %0d", r.d, r.addr,
                         $signed(rdata[r.d]), $signed(r.val));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start = '0;
        stop  = '0;
        stb   = '0;
    endtask

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
        end
    endtask

    task automatic strobe(int d, logic [7:0] v);
        stb[d] = 1'b1;
        ain[d] = v;
        step();
    endtask

    task automatic rd(int d, int a, logic [7:0] v);
        raddr[d] = 16'(a);
        rd_q.push_back('{d, cyc + 2, v, a});
        step();
    endtask

    task automatic finish_rec(int d, int len);
        done_q.push_back('{d, 17'(len)});
        stop[d] = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0] t1 [5] = '{8'd10, -8'sd20, 8'd30, 8'h80, 8'd127};
        rst = 1'b1; start = '0; stop = '0; stb = '0;
        for (int d = 0; d < 3; d++) begin ain[d] = '0; raddr[d] = '0; end
        repeat (3) step();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset armed", d, 32'(armed[d]), 0);
            chk("reset recording", d, 32'(recording[d]), 0);
            chk("reset rec_len", d, 32'(rlen[d]), 0);
            chk("reset rec_done", d, 32'(done[d]), 0);
            chk("reset rd_data", d, 32'(rdata[d]), 0);
        end
        // basic capture and readback
        start[0] = 1'b1; step();
        chk("armed after start", 0, 32'(armed[0]), 1);
        chk("not recording while armed", 0, 32'(recording[0]), 0);
        for (int i = 0; i < 5; i++) begin
            strobe(0, t1[i]);
            if (i == 0) begin
                chk("recording after trigger", 0, 32'(recording[0]), 1);
                chk("armed cleared", 0, 32'(armed[0]), 0);
                chk("rd_data forced 0", 0, 32'(rdata[0]), 0);
            end
        end
        chk("rec_len holds", 0, 32'(rlen[0]), 0);
        finish_rec(0, 5);
        chk("recording ends on stop", 0, 32'(recording[0]), 0);
        step();
        for (int i = 0; i < 5; i++) rd(0, i, t1[i]);
        repeat (3) step();
        // reset mid-recording
        start[0] = 1'b1; step();
        for (int i = 0; i < 6; i++) strobe(0, 8'(11 + i));
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst armed", 0, 32'(armed[0]), 0);
        chk("rst recording", 0, 32'(recording[0]), 0);
        chk("rst rec_len", 0, 32'(rlen[0]), 0);
        chk("rst rec_done", 0, 32'(done[0]), 0);
        chk("rst rd_data", 0, 32'(rdata[0]), 0);
        repeat (2) step();
        for (int i = 0; i < 6; i++) rd(0, i, 8'(11 + i));
        repeat (3) step();
        // stop coincident with the 4th strobe, then stop while armed
        start[0] = 1'b1; step();
        for (int i = 1; i <= 3; i++) strobe(0, 8'(i));
        stb[0] = 1'b1; ain[0] = 8'd99;
        finish_rec(0, 3);
        step();
        rd(0, 0, 8'd1); rd(0, 1, 8'd2); rd(0, 2, 8'd3); rd(0, 3, 8'd14);
        repeat (3) step();
        start[0] = 1'b1; step();
        finish_rec(0, 0);
        chk("armed cleared by stop", 0, 32'(armed[0]), 0);
        // start ignored while recording; start+stop in idle arms
        start[0] = 1'b1; step();
        strobe(0, 8'd5);
        start[0] = 1'b1; strobe(0, 8'd6);
        chk("start ignored in record", 0, 32'(recording[0]), 1);
        chk("start ignored not armed", 0, 32'(armed[0]), 0);
        finish_rec(0, 2);
        start[0] = 1'b1; stop[0] = 1'b1; step();
        chk("start+stop arms", 0, 32'(armed[0]), 1);
        finish_rec(0, 0);
        step();
        rd(0, 0, 8'd5); rd(0, 1, 8'd6);
        repeat (3) step();
        // level trigger
        start[1] = 1'b1; step();
        strobe(1, 8'd3);
        chk("below threshold armed", 1, 32'(armed[1]), 1);
        strobe(1, -8'sd49);
        chk("below threshold not rec", 1, 32'(recording[1]), 0);
        strobe(1, -8'sd50);
        chk("threshold triggers", 1, 32'(recording[1]), 1);
        strobe(1, 8'd7);
        finish_rec(1, 2);
        step();
        rd(1, 0, -8'sd50); rd(1, 1, 8'd7);
        repeat (3) step();
        // fill to capacity
        done_q.push_back('{2, 17'd16});
        start[2] = 1'b1; step();
        for (int i = 0; i < 20; i++) begin
            strobe(2, 8'(i));
            if (i == 14) chk("recording before full", 2, 32'(recording[2]), 1);
        end
        chk("stopped when full", 2, 32'(recording[2]), 0);
        chk("full rec_len", 2, 32'(rlen[2]), 16);
        for (int i = 0; i < 16; i++) rd(2, i, 8'(i));
        repeat (4) step();
        chk("missing rec_done pulses", 0, 32'(done_q.size()), 0);
        chk("unchecked reads", 0, 32'(rd_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
